// File: rtl/game_flow_ctrl.sv
// Game-flow controller: tick generator, game FSM, lives/level/score,
// respawn position and per-level oscillating lava height.
module game_flow_ctrl #(
  parameter int TICK_DIV      = 833334,
  parameter int NUM_LEVELS    = 4,
  parameter int LEVEL_W       = 2,
  parameter int START_LIVES   = 3,
  parameter logic [2**LEVEL_W-1:0] LAVA_MASK = 4'b0001,
  parameter int LAVA_TOP      = 380,
  parameter int LAVA_SPEED    = 3,
  parameter int LAVA_STEP_INC = 1,
  parameter int BOOST_STEP    = 2,
  parameter int RESPAWN_TICKS = 60,
  parameter int CLEAR_TICKS   = 90,
  parameter int SPAWN_X       = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_lava,
  input  logic               at_goal_region,
  input  logic               jump_landed_pulse,
  input  logic               pause_pulse,
  input  logic               restart_pulse,
  output logic               game_tick,
  output logic [2:0]         game_state,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         lives,
  output logic [15:0]        score,
  output logic [9:0]         lava_height,
  output logic [9:0]         player_x_reset,
  output logic [9:0]         player_y_reset,
  output logic               respawn_pulse
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_RUNNING     = 3'd0,
    S_GAME_OVER   = 3'd1,
    S_WIN         = 3'd2,
    S_PAUSED      = 3'd3,
    S_DYING       = 3'd4,
    S_LEVEL_CLEAR = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               tick_q;
  logic               tick;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [2:0]         lives_q, lives_d;
  logic [15:0]        score_q, score_d;
  logic [9:0]         lava_q, lava_d;
  logic               rise_q, rise_d;
  logic [15:0]        hold_q, hold_d;
  logic [9:0]         ypos_q, ypos_d;
  logic               resp_q, resp_d;
  logic               pp_q, pp_d;
  logic               pr_q, pr_d;
  logic               pl_q, pl_d;
  logic [10:0]        step, sum, diff;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CW'(1);
      tick_q <= tick;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUNNING;
      level_q <= '0;
      lives_q <= 3'(START_LIVES);
      score_q <= '0;
      lava_q  <= '0;
      rise_q  <= 1'b1;
      hold_q  <= '0;
      ypos_q  <= 10'd344;
      resp_q  <= 1'b0;
      pp_q    <= 1'b0;
      pr_q    <= 1'b0;
      pl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      score_q <= score_d;
      lava_q  <= lava_d;
      rise_q  <= rise_d;
      hold_q  <= hold_d;
      ypos_q  <= ypos_d;
      resp_q  <= resp_d;
      pp_q    <= pp_d;
      pr_q    <= pr_d;
      pl_q    <= pl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    score_d = score_q;
    lava_d  = lava_q;
    rise_d  = rise_q;
    hold_d  = hold_q;
    ypos_d  = ypos_q;
    resp_d  = 1'b0;
    // a pulse landing on the consuming clk survives into the next tick
    pp_d    = tick ? pause_pulse : (pp_q | pause_pulse);
    pr_d    = tick ? restart_pulse : (pr_q | restart_pulse);
    pl_d    = tick ? jump_landed_pulse : (pl_q | jump_landed_pulse);
    step    = 11'(LAVA_SPEED) + 11'(level_q) * 11'(LAVA_STEP_INC)
            + ((rise_q && pl_q) ? 11'(BOOST_STEP) : 11'd0);
    sum     = {1'b0, lava_q} + step;
    diff    = {1'b0, lava_q} - step;
    if (tick) begin
      if (pr_q) begin
        state_d = S_RUNNING;
        level_d = '0;
        lives_d = 3'(START_LIVES);
        score_d = '0;
        lava_d  = '0;
        rise_d  = 1'b1;
        hold_d  = '0;
        ypos_d  = 10'd344;
        resp_d  = 1'b1;
      end else begin
        unique case (state_q)
          S_RUNNING: begin
            if (!LAVA_MASK[level_q]) begin
              lava_d = '0;
              rise_d = 1'b1;
            end else if (rise_q) begin
              if (sum >= 11'(LAVA_TOP)) begin
                lava_d = 10'(LAVA_TOP);
                rise_d = 1'b0;
              end else begin
                lava_d = sum[9:0];
              end
            end else if ({1'b0, lava_q} >= step) begin
              lava_d = diff[9:0];
            end else begin
              lava_d = '0;
              rise_d = 1'b1;
            end
            if (pl_q && score_q != 16'hFFFF)
              score_d = score_q + 16'd1;
            if (in_lava) begin
              lives_d = lives_q - 3'd1;
              if (lives_q == 3'd1) begin
                state_d = S_GAME_OVER;
              end else begin
                state_d = S_DYING;
                hold_d  = 16'(RESPAWN_TICKS);
              end
            end else if (at_goal_region) begin
              if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
                state_d = S_WIN;
              end else begin
                state_d = S_LEVEL_CLEAR;
                hold_d  = 16'(CLEAR_TICKS);
              end
            end else if (pp_q) begin
              state_d = S_PAUSED;
            end
          end
          S_PAUSED: begin
            if (pp_q)
              state_d = S_RUNNING;
          end
          S_DYING, S_LEVEL_CLEAR: begin
            if (hold_q == 16'd1) begin
              state_d = S_RUNNING;
              resp_d  = 1'b1;
              lava_d  = '0;
              rise_d  = 1'b1;
              if (state_q == S_LEVEL_CLEAR) begin
                level_d = level_q + LEVEL_W'(1);
                ypos_d  = 10'd364;
              end
            end else begin
              hold_d = hold_q - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    game_state     = state_q;
    freeze         = (state_q != S_RUNNING);
    game_tick      = tick_q;
    level          = level_q;
    lives          = lives_q;
    score          = score_q;
    lava_height    = lava_q;
    player_x_reset = 10'(SPAWN_X);
    player_y_reset = ypos_q;
    respawn_pulse  = resp_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table of one-tick steps
// plus hand-written lava, pause-timing, saturation and reset sequences.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_lava = 1'b0;
  logic       at_goal_region = 1'b0;
  logic       jump_landed_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       restart_pulse = 1'b0;
  logic       game_tick;
  logic [2:0] game_state;
  logic       freeze;
  logic [1:0] level;
  logic [2:0] lives;
  logic [15:0] score;
  logic [9:0] lava_height;
  logic [9:0] player_x_reset;
  logic [9:0] player_y_reset;
  logic       respawn_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  game_flow_ctrl #(
    .TICK_DIV(4), .NUM_LEVELS(4), .LEVEL_W(2), .START_LIVES(2),
    .LAVA_MASK(4'b0001), .LAVA_TOP(380), .LAVA_SPEED(3),
    .LAVA_STEP_INC(1), .BOOST_STEP(2), .RESPAWN_TICKS(3),
    .CLEAR_TICKS(3), .SPAWN_X(20)
  ) dut (
    .clk(clk), .rst(rst), .in_lava(in_lava),
    .at_goal_region(at_goal_region),
    .jump_landed_pulse(jump_landed_pulse),
    .pause_pulse(pause_pulse), .restart_pulse(restart_pulse),
    .game_tick(game_tick), .game_state(game_state), .freeze(freeze),
    .level(level), .lives(lives), .score(score),
    .lava_height(lava_height), .player_x_reset(player_x_reset),
    .player_y_reset(player_y_reset), .respawn_pulse(respawn_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lv, gl, ld, ps, rs;
    int st, lives, lvl, score, lava, resp;
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, ".tick"}, game_tick, 0);
    check({t, ".state"}, game_state, 0);
    check({t, ".freeze"}, freeze, 0);
    check({t, ".level"}, level, 0);
    check({t, ".lives"}, lives, 2);
    check({t, ".score"}, score, 0);
    check({t, ".lava"}, lava_height, 0);
    check({t, ".x"}, player_x_reset, 20);
    check({t, ".y"}, player_y_reset, 344);
    check({t, ".resp"}, respawn_pulse, 0);
  endtask

  task automatic check_outs(input string t, input int st, input int lv,
                            input int lvl, input int sc, input int lava,
                            input int resp);
    check({t, ".state"}, game_state, st);
    check({t, ".freeze"}, freeze, (st != 0) ? 1 : 0);
    check({t, ".lives"}, lives, lv);
    check({t, ".level"}, level, lvl);
    check({t, ".score"}, score, sc);
    check({t, ".lava"}, lava_height, lava);
    check({t, ".resp"}, respawn_pulse, resp);
    check({t, ".x"}, player_x_reset, 20);
    check({t, ".y"}, player_y_reset, (lvl == 0) ? 344 : 364);
  endtask

  task automatic wait_tick(input string t);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = game_tick;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.tick_timeout: got no tick, want tick within 8 clks", t);
    end
  endtask

  task automatic apply(input bit lv, input bit gl, input bit ld,
                       input bit ps, input bit rs, input string t);
    in_lava = lv;
    at_goal_region = gl;
    jump_landed_pulse = ld;
    pause_pulse = ps;
    restart_pulse = rs;
    @(negedge clk);
    jump_landed_pulse = 1'b0;
    pause_pulse = 1'b0;
    restart_pulse = 1'b0;
    wait_tick(t);
  endtask

  initial begin
    //            lv gl ld ps rs  st lv lvl sc lava resp
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 2, 0, 1, 14, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 2, 0, 1, 17, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 3, 2, 0, 1, 20, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 3, 2, 0, 1, 20, 0};
    vecs[4]  = '{0, 0, 1, 0, 0, 3, 2, 0, 1, 20, 0};
    vecs[5]  = '{1, 0, 0, 1, 0, 0, 2, 0, 1, 20, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 2, 0, 1, 23, 0};
    vecs[7]  = '{1, 1, 0, 1, 0, 4, 1, 0, 1, 26, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 4, 1, 0, 1, 26, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 4, 1, 0, 1, 26, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[11] = '{0, 1, 0, 0, 0, 5, 1, 0, 1, 3, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 5, 1, 0, 1, 3, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 5, 1, 0, 1, 3, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 0, 5, 1, 1, 2, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 5, 1, 1, 2, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 5, 1, 1, 2, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 1};
    vecs[21] = '{0, 1, 0, 0, 0, 5, 1, 2, 2, 0, 0};
    vecs[22] = '{0, 0, 0, 0, 0, 5, 1, 2, 2, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 5, 1, 2, 2, 0, 0};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 1, 3, 2, 0, 1};
    vecs[25] = '{0, 1, 0, 0, 0, 2, 1, 3, 2, 0, 0};
    vecs[26] = '{0, 0, 1, 0, 0, 2, 1, 3, 2, 0, 0};
    vecs[27] = '{0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1};
    vecs[28] = '{0, 0, 0, 0, 0, 0, 2, 0, 0, 3, 0};
    vecs[29] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 6, 0};
    vecs[30] = '{0, 0, 0, 0, 0, 4, 1, 0, 0, 6, 0};
    vecs[31] = '{0, 0, 0, 0, 0, 4, 1, 0, 0, 6, 0};
    vecs[32] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[33] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0};
    vecs[34] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0};
    vecs[35] = '{0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("tick.c%0d", c), game_tick, (c % 4 == 0) ? 1 : 0);
    end
    check("tick.lava", lava_height, 9);
    @(negedge clk);

    for (int i = 0; i < 36; i++) begin
      apply(vecs[i].lv, vecs[i].gl, vecs[i].ld, vecs[i].ps, vecs[i].rs,
            $sformatf("v%0d", i));
      check_outs($sformatf("v%0d", i), vecs[i].st, vecs[i].lives,
                 vecs[i].lvl, vecs[i].score, vecs[i].lava, vecs[i].resp);
    end

    for (int i = 1; i <= 126; i++)
      apply(0, 0, 0, 0, 0, "lavaup");
    check("lava.126", lava_height, 378);
    apply(0, 0, 0, 0, 0, "lava127");
    check("lava.127", lava_height, 380);
    apply(0, 0, 0, 0, 0, "lava128");
    check("lava.128", lava_height, 377);

    repeat (3) @(negedge clk);
    pause_pulse = 1'b1;
    @(negedge clk);
    pause_pulse = 1'b0;
    check("coinc.tick", game_tick, 1);
    check("coinc.state", game_state, 0);
    check("coinc.lava", lava_height, 374);
    apply(0, 0, 0, 0, 0, "coinc2");
    check("coinc2.state", game_state, 3);
    check("coinc2.lava", lava_height, 371);
    apply(0, 0, 0, 1, 0, "unpause");
    check("unpause.state", game_state, 0);
    check("unpause.lava", lava_height, 371);
    check("unpause.resp", respawn_pulse, 0);

    force dut.score_q = 16'hFFFE;
    @(negedge clk);
    release dut.score_q;
    apply(0, 0, 1, 0, 0, "sat1");
    check("sat1.score", score, 65535);
    check("sat1.lava", lava_height, 368);
    apply(0, 0, 1, 0, 0, "sat2");
    check("sat2.score", score, 65535);
    check("sat2.lava", lava_height, 365);

    apply(1, 0, 0, 0, 0, "die");
    check_outs("die", 4, 1, 0, 65535, 362, 0);
    apply(0, 0, 0, 0, 0, "die2");
    check("die2.state", game_state, 4);
    rst = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
